// File: rtl/mult_div_unit_if.sv
// Pipeline-side bundle for the iterative multiply/divide unit.
// The stall logic drives start/operands; the unit returns status and HI/LO.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       operation;
    logic [WIDTH-1:0] inputOne;
    logic [WIDTH-1:0] inputTwo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             divByZero;

    modport master (
        output start, operation, inputOne, inputTwo,
        input  busy, done, hi, lo, divByZero
    );

    modport slave (
        input  start, operation, inputOne, inputTwo,
        output busy, done, hi, lo, divByZero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per clock, results into HI/LO.
// Signed ops run on magnitudes; sign correction happens on the final step.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clock,
    input  logic           resetN,
    mult_div_unit_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d, b_q, b_d;
    logic             negq_q, negq_d, negr_q, negr_d;
    logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic [WIDTH:0]     sum, shifted, diff, acc_s;
    logic [WIDTH-1:0]   q_s, addend, quo, rem;
    logic [2*WIDTH-1:0] prod;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    // One shift-add (multiply) or restoring shift-subtract (divide) step
    always_comb begin
        addend  = q_q[0] ? b_q : '0;
        sum     = (WIDTH+1)'(acc_q[WIDTH-1:0]) + (WIDTH+1)'(addend);
        shifted = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        diff    = shifted - (WIDTH+1)'(b_q);
        if (op_q[1]) begin
            if (!diff[WIDTH]) begin
                acc_s = diff;
                q_s   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_s = shifted;
                q_s   = {q_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_s = {1'b0, sum[WIDTH:1]};
            q_s   = {sum[0], q_q[WIDTH-1:1]};
        end
        prod = {acc_s[WIDTH-1:0], q_s};
        if (negq_q) prod = -prod;
        quo = negq_q ? -q_s : q_s;
        rem = negr_q ? -acc_s[WIDTH-1:0] : acc_s[WIDTH-1:0];
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        q_d     = q_q;
        b_d     = b_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        a_neg = bus.operation[0] & bus.inputOne[WIDTH-1];
        b_neg = bus.operation[0] & bus.inputTwo[WIDTH-1];
        a_mag = a_neg ? -bus.inputOne : bus.inputOne;
        b_mag = b_neg ? -bus.inputTwo : bus.inputTwo;

        case (state_q)
            RUN: begin
                acc_d = acc_s;
                q_d   = q_s;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    hi_d    = op_q[1] ? rem : prod[2*WIDTH-1:WIDTH];
                    lo_d    = op_q[1] ? quo : prod[WIDTH-1:0];
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                if (bus.start) begin
                    op_d   = bus.operation;
                    acc_d  = '0;
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    dbz_d  = 1'b0;
                    // Dividend/multiplier shifts through q; divisor/multiplicand sits in b
                    q_d    = bus.operation[1] ? a_mag : b_mag;
                    b_d    = bus.operation[1] ? b_mag : a_mag;
                    if (bus.operation[1] && (bus.inputTwo == '0)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        dbz_d   = 1'b1;
                        hi_d    = bus.inputOne;
                        lo_d    = '1;
                    end else begin
                        state_d = RUN;
                        cnt_d   = CW'(WIDTH - 1);
                        busy_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            b_q     <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            b_q     <= b_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.divByZero = dbz_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus randomized ops checked
// against an arithmetic reference model.
module tb_mult_div_unit;
    localparam int unsigned W = 32;

    logic clock = 1'b0;
    logic resetN;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .resetN(resetN),
        .bus   (bus)
    );

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] ehi, output logic [31:0] elo, output logic edbz);
        logic [63:0] p;
        longint      sa, sb, sq, sr;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        edbz = 1'b0;
        case (op)
            2'd0: begin p = {32'b0, a} * {32'b0, b}; ehi = p[63:32]; elo = p[31:0]; end
            2'd1: begin sq = sa * sb; p = 64'(sq); ehi = p[63:32]; elo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    ehi = a; elo = 32'hFFFF_FFFF; edbz = 1'b1;
                end else if (op == 2'd2) begin
                    elo = a / b; ehi = a % b;
                end else begin
                    sq = sa / sb; sr = sa % sb;
                    elo = sq[31:0]; ehi = sr[31:0];
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 100));
            default: return 32'($urandom);
        endcase
    endfunction

    // Present one start for a single edge, then scramble the operand inputs
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start     = 1'b1;
        bus.operation = op;
        bus.inputOne  = a;
        bus.inputTwo  = b;
        @(negedge clock);
        bus.start     = 1'b0;
        bus.operation = 2'($urandom);
        bus.inputOne  = 32'($urandom);
        bus.inputTwo  = 32'($urandom);
    endtask

    // Called in cycle 1 after a start; returns the cycle index of done
    task automatic wait_done(output int lat, output int busy_cycles, output bit early);
        logic [31:0] h0, l0;
        h0 = bus.hi; l0 = bus.lo;
        lat = 0; busy_cycles = 0; early = 1'b0;
        while (lat < 200) begin
            lat++;
            if (bus.done === 1'b1) break;
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.hi !== h0 || bus.lo !== l0) early = 1'b1;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        bus.start = 1'b0; bus.operation = 2'd0; bus.inputOne = '0; bus.inputTwo = '0;
        repeat (3) @(negedge clock);
        total++;
        if ({bus.busy, bus.done, bus.divByZero, bus.hi, bus.lo} !== 67'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b dbz=%b hi=%h lo=%h required all 0",
                     bus.busy, bus.done, bus.divByZero, bus.hi, bus.lo);
        end
        resetN = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_multu_basic();
        int lat, bc; bit early;
        issue(2'd0, 32'd4, 32'd8);
        wait_done(lat, bc, early);
        total++; if (lat !== 33) begin bad++; $display("FAIL basic_latency: got %0d required 33", lat); end
        total++; if (bc !== 32) begin bad++; $display("FAIL basic_busy_cycles: got %0d required 32", bc); end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL basic_partial: hi/lo changed before done"); end
        total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd32) begin
            bad++; $display("FAIL basic_result: hi=%h lo=%h required 0/00000020", bus.hi, bus.lo); end
        @(negedge clock);
        total++; if (bus.done !== 1'b0 || bus.lo !== 32'd32) begin
            bad++; $display("FAIL basic_pulse_hold: done=%b lo=%h required 0/00000020", bus.done, bus.lo); end
    endtask

    task automatic test_directed();
        logic [1:0]  ops [5] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd3};
        logic [31:0] as  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd17, 32'hFFFF_FFEF, 32'h8000_0000};
        logic [31:0] bs  [5] = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'd5, 32'hFFFF_FFFF};
        logic [31:0] ehs [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFE, 32'd0};
        logic [31:0] els [5] = '{32'hFFFF_FFF1, 32'd1, 32'd8, 32'hFFFF_FFFD, 32'h8000_0000};
        int lat, bc; bit early;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(lat, bc, early);
            total++; if (lat !== 33) begin bad++; $display("FAIL directed%0d_latency: got %0d required 33", i, lat); end
            total++; if (bus.hi !== ehs[i] || bus.lo !== els[i] || bus.divByZero !== 1'b0) begin
                bad++; $display("FAIL directed%0d_result: hi=%h lo=%h dbz=%b required %h/%h/0",
                                i, bus.hi, bus.lo, bus.divByZero, ehs[i], els[i]); end
            @(negedge clock);
        end
    endtask

    task automatic test_div_zero();
        int lat, bc; bit early;
        issue(2'd2, 32'd10, 32'd0);
        wait_done(lat, bc, early);
        total++; if (lat !== 1) begin bad++; $display("FAIL dz_latency: got %0d required 1", lat); end
        total++; if (bus.divByZero !== 1'b1 || bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'h0000_000A) begin
            bad++; $display("FAIL dz_result: dbz=%b lo=%h hi=%h required 1/ffffffff/0000000a",
                            bus.divByZero, bus.lo, bus.hi); end
        repeat (3) @(negedge clock);
        total++; if (bus.divByZero !== 1'b1 || bus.done !== 1'b0) begin
            bad++; $display("FAIL dz_hold: dbz=%b done=%b required 1/0", bus.divByZero, bus.done); end
        issue(2'd3, 32'hFFFF_FF00, 32'd0);
        wait_done(lat, bc, early);
        total++; if (lat !== 1 || bus.hi !== 32'hFFFF_FF00 || bus.divByZero !== 1'b1) begin
            bad++; $display("FAIL dz_signed: lat=%0d hi=%h dbz=%b required 1/ffffff00/1", lat, bus.hi, bus.divByZero); end
        @(negedge clock);
        issue(2'd0, 32'd2, 32'd3);
        total++; if (bus.divByZero !== 1'b0) begin
            bad++; $display("FAIL dz_clear: dbz=%b required 0 after start", bus.divByZero); end
        wait_done(lat, bc, early);
        total++; if (lat !== 33 || bus.lo !== 32'd6 || bus.divByZero !== 1'b0) begin
            bad++; $display("FAIL dz_next: lat=%0d lo=%h dbz=%b required 33/6/0", lat, bus.lo, bus.divByZero); end
        @(negedge clock);
    endtask

    task automatic test_ignore_start();
        int lat, bc; bit early;
        issue(2'd0, 32'd4, 32'd8);
        repeat (8) @(negedge clock);
        bus.start = 1'b1; bus.operation = 2'd2; bus.inputOne = 32'd9; bus.inputTwo = 32'd3;
        @(negedge clock);
        bus.start = 1'b0;
        wait_done(lat, bc, early);
        total++; if (lat !== 24) begin bad++; $display("FAIL ignore_latency: got %0d required 24", lat); end
        total++; if (bus.lo !== 32'd32 || bus.hi !== 32'd0 || bus.divByZero !== 1'b0) begin
            bad++; $display("FAIL ignore_result: hi=%h lo=%h dbz=%b required 0/20/0", bus.hi, bus.lo, bus.divByZero); end
        @(negedge clock);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignore_queued: busy=%b required 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int lat, bc; bit early;
        issue(2'd0, 32'd4, 32'd8);
        wait_done(lat, bc, early);
        issue(2'd3, 32'hFFFF_FFEF, 32'd5);
        wait_done(lat, bc, early);
        total++; if (lat !== 33) begin bad++; $display("FAIL b2b_latency: got %0d required 33", lat); end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL b2b_partial: hi/lo changed before done"); end
        total++; if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'hFFFF_FFFD) begin
            bad++; $display("FAIL b2b_result: hi=%h lo=%h required fffffffe/fffffffd", bus.hi, bus.lo); end
        issue(2'd2, 32'd10, 32'd0);
        wait_done(lat, bc, early);
        issue(2'd0, 32'd2, 32'd3);
        wait_done(lat, bc, early);
        total++; if (lat !== 33 || bus.lo !== 32'd6 || bus.divByZero !== 1'b0) begin
            bad++; $display("FAIL b2b_after_dz: lat=%0d lo=%h dbz=%b required 33/6/0", lat, bus.lo, bus.divByZero); end
        @(negedge clock);
    endtask

    task automatic test_reset_abort();
        int lat, bc, dones; bit early;
        issue(2'd2, 32'd17, 32'd2);
        repeat (11) @(negedge clock);
        resetN = 1'b0;
        #1;
        total++; if ({bus.busy, bus.done, bus.divByZero, bus.hi, bus.lo} !== 67'd0) begin
            bad++; $display("FAIL abort_reset: busy=%b done=%b hi=%h lo=%h required all 0",
                            bus.busy, bus.done, bus.hi, bus.lo); end
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done: got %0d active cycles required 0", dones); end
        issue(2'd0, 32'd4, 32'd8);
        wait_done(lat, bc, early);
        total++; if (lat !== 33 || bus.lo !== 32'd32) begin
            bad++; $display("FAIL abort_recover: lat=%0d lo=%h required 33/20", lat, bus.lo); end
        @(negedge clock);
    endtask

    task automatic test_random();
        int lat, bc; bit early;
        logic [1:0]  op;
        logic [31:0] a, b, ehi, elo;
        logic        edbz;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom);
            a  = pick();
            b  = pick();
            model(op, a, b, ehi, elo, edbz);
            issue(op, a, b);
            wait_done(lat, bc, early);
            total++; if (lat !== (edbz ? 1 : 33) || bc !== (edbz ? 0 : 32)) begin
                bad++; $display("FAIL rand%0d_timing: lat=%0d busy=%0d op=%0d b=%h", i, lat, bc, op, b); end
            total++; if (bus.hi !== ehi || bus.lo !== elo || bus.divByZero !== edbz) begin
                bad++; $display("FAIL rand%0d_result: op=%0d a=%h b=%h got %h/%h/%b required %h/%h/%b",
                                i, op, a, b, bus.hi, bus.lo, bus.divByZero, ehi, elo, edbz); end
            total++; if (early !== 1'b0) begin bad++; $display("FAIL rand%0d_partial: hi/lo changed before done", i); end
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_multu_basic();
        test_directed();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
